// File: rtl/dram_addr_demux_if.sv
// DRAM strobe/address pin bundle plus the decoded access/refresh outputs.
interface dram_addr_demux_if #(
   parameter int AW = 8
);
   logic            nras;
   logic            ncas;
   logic            nwe;
   logic [AW-1:0]   ma;
   logic [2*AW-1:0] addr;
   logic            acc_valid;
   logic            acc_write;
   logic            page_hit;
   logic            refresh;
   logic [AW-1:0]   refresh_row;
   logic            proto_err;

   modport master (
      output nras, ncas, nwe, ma,
      input  addr, acc_valid, acc_write, page_hit, refresh, refresh_row, proto_err
   );

   modport slave (
      input  nras, ncas, nwe, ma,
      output addr, acc_valid, acc_write, page_hit, refresh, refresh_row, proto_err
   );
endinterface

// File: rtl/dram_addr_demux.sv
// Snoops asynchronous DRAM strobes and rebuilds {row,col} accesses, refreshes and protocol errors.
//   state | meaning
//   IDLE  | RAS high, waiting for a RAS fall
//   ROW   | row latched, waiting for a CAS fall or RAS rise
//   COL   | column captured, CAS low
//   HOLD  | CBR refresh or bad strobe cycle, waiting for RAS rise
module dram_addr_demux #(
   parameter int AW          = 8,
   parameter int SYNC_STAGES = 2   // legal 2..4
) (
   input logic               clk,
   input logic               rst_n,
   dram_addr_demux_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ROW, COL, HOLD} state_t;

   state_t state, state_nxt;

   // Sync stages [SYNC_STAGES-1:0]; bit SYNC_STAGES is the edge-detect reference.
   logic [SYNC_STAGES:0]   ras_sh;
   logic [SYNC_STAGES:0]   cas_sh;
   logic [SYNC_STAGES-1:0] nwe_sh;
   logic [AW-1:0]          ma_sh [SYNC_STAGES];

   logic            ras_fall, ras_rise, cas_fall, cas_rise, cas_low;
   logic            nwe_cur;
   logic [AW-1:0]   ma_cur;

   logic            acc_fire, cbr_fire, ror_fire, err_fire, row_ld;

   logic [AW-1:0]   row_q;
   logic [AW-1:0]   cbr_cnt;
   logic            cas_seen;
   logic [2*AW-1:0] addr_q;
   logic            acc_valid_q, acc_write_q, page_hit_q, refresh_q, proto_err_q;
   logic [AW-1:0]   refresh_row_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ras_sh <= '1;
         cas_sh <= '1;
         nwe_sh <= '1;
         for (int i = 0; i < SYNC_STAGES; i++) ma_sh[i] <= '0;
      end else begin
         ras_sh   <= {ras_sh[SYNC_STAGES-1:0], bus.nras};
         cas_sh   <= {cas_sh[SYNC_STAGES-1:0], bus.ncas};
         nwe_sh   <= {nwe_sh[SYNC_STAGES-2:0], bus.nwe};
         ma_sh[0] <= bus.ma;
         for (int i = 1; i < SYNC_STAGES; i++) ma_sh[i] <= ma_sh[i-1];
      end
   end

   assign ras_fall = ras_sh[SYNC_STAGES]  & ~ras_sh[SYNC_STAGES-1];
   assign ras_rise = ~ras_sh[SYNC_STAGES] &  ras_sh[SYNC_STAGES-1];
   assign cas_fall = cas_sh[SYNC_STAGES]  & ~cas_sh[SYNC_STAGES-1];
   assign cas_rise = ~cas_sh[SYNC_STAGES] &  cas_sh[SYNC_STAGES-1];
   assign cas_low  = ~cas_sh[SYNC_STAGES-1];
   assign nwe_cur  = nwe_sh[SYNC_STAGES-1];
   assign ma_cur   = ma_sh[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (ras_fall) state_nxt = (cas_low) ? HOLD : ROW;
         ROW:  if (ras_rise) state_nxt = IDLE;
               else if (cas_fall) state_nxt = COL;
         COL:  if (ras_rise) state_nxt = IDLE;
               else if (cas_rise) state_nxt = ROW;
         HOLD: if (ras_rise) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A RAS rise in ROW wins over a coincident CAS fall: the access is incomplete.
   always_comb begin
      acc_fire = 1'b0;
      cbr_fire = 1'b0;
      ror_fire = 1'b0;
      err_fire = 1'b0;
      row_ld   = 1'b0;
      case (state)
         IDLE: if (ras_fall) begin
            if (cas_fall)     err_fire = 1'b1;
            else if (cas_low) cbr_fire = 1'b1;
            else              row_ld   = 1'b1;
         end
         ROW: if (ras_rise)      ror_fire = ~cas_seen;
              else if (cas_fall) acc_fire = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q         <= '0;
         cbr_cnt       <= '0;
         cas_seen      <= 1'b0;
         addr_q        <= '0;
         acc_valid_q   <= 1'b0;
         acc_write_q   <= 1'b0;
         page_hit_q    <= 1'b0;
         refresh_q     <= 1'b0;
         refresh_row_q <= '0;
         proto_err_q   <= 1'b0;
      end else begin
         acc_valid_q <= acc_fire;
         refresh_q   <= cbr_fire | ror_fire;
         proto_err_q <= err_fire;
         if (row_ld) begin
            row_q    <= ma_cur;
            cas_seen <= 1'b0;
         end
         if (acc_fire) begin
            addr_q      <= {row_q, ma_cur};
            acc_write_q <= ~nwe_cur;
            page_hit_q  <= cas_seen;
            cas_seen    <= 1'b1;
         end
         if (cbr_fire) begin
            refresh_row_q <= cbr_cnt;
            cbr_cnt       <= cbr_cnt + 1'b1;
         end
         if (ror_fire) refresh_row_q <= row_q;
      end
   end

   assign bus.addr        = addr_q;
   assign bus.acc_valid   = acc_valid_q;
   assign bus.acc_write   = acc_write_q;
   assign bus.page_hit    = page_hit_q;
   assign bus.refresh     = refresh_q;
   assign bus.refresh_row = refresh_row_q;
   assign bus.proto_err   = proto_err_q;

endmodule

// File: tb/tb_dram_addr_demux.sv
// Directed bench for dram_addr_demux: protocol model compared every cycle plus literal event checks.
module tb_dram_addr_demux;
   localparam int AW = 8;
   localparam int S  = 2;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   nchk = 0;
   int   nerr = 0;

   dram_addr_demux_if #(.AW(AW)) bus ();

   dram_addr_demux #(.AW(AW), .SYNC_STAGES(S)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Protocol model: a pin value taken at a clock edge is acted on S edges later.
   logic [S:0]    h_ras, h_cas, h_nwe;
   logic [AW-1:0] h_ma [0:S];
   logic          ras_open, cas_down, cas_seen, ignoring;
   logic [AW-1:0] m_row, m_cbr, m_refresh_row;
   logic [15:0]   m_addr;
   logic          m_acc_valid, m_acc_write, m_page_hit, m_refresh, m_proto;

   wire ras_fall = h_ras[S]  & ~h_ras[S-1];
   wire ras_rise = ~h_ras[S] &  h_ras[S-1];
   wire cas_fall = h_cas[S]  & ~h_cas[S-1];
   wire cas_rise = ~h_cas[S] &  h_cas[S-1];
   wire cas_now_low = ~h_cas[S-1];
   wire [AW-1:0] ma_now = h_ma[S-1];
   wire nwe_now = h_nwe[S-1];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_ras <= '1; h_cas <= '1; h_nwe <= '1;
         for (int k = 0; k <= S; k++) h_ma[k] <= '0;
         ras_open <= 0; cas_down <= 0; cas_seen <= 0; ignoring <= 0;
         m_row <= 0; m_cbr <= 0; m_refresh_row <= 0; m_addr <= 0;
         m_acc_valid <= 0; m_acc_write <= 0; m_page_hit <= 0; m_refresh <= 0; m_proto <= 0;
      end else begin
         h_ras <= {h_ras[S-1:0], bus.nras};
         h_cas <= {h_cas[S-1:0], bus.ncas};
         h_nwe <= {h_nwe[S-1:0], bus.nwe};
         h_ma[0] <= bus.ma;
         for (int k = 1; k <= S; k++) h_ma[k] <= h_ma[k-1];
         m_acc_valid <= 0; m_refresh <= 0; m_proto <= 0;
         if (ignoring) begin
            if (ras_rise) ignoring <= 0;
         end else if (!ras_open) begin
            if (ras_fall) begin
               if (cas_fall) begin
                  m_proto <= 1; ignoring <= 1;
               end else if (cas_now_low) begin
                  m_refresh <= 1; m_refresh_row <= m_cbr; m_cbr <= m_cbr + 1; ignoring <= 1;
               end else begin
                  m_row <= ma_now; ras_open <= 1; cas_seen <= 0; cas_down <= 0;
               end
            end
         end else begin
            if (ras_rise) begin
               ras_open <= 0; cas_down <= 0;
               if (!cas_seen) begin m_refresh <= 1; m_refresh_row <= m_row; end
            end else if (!cas_down && cas_fall) begin
               m_acc_valid <= 1; m_addr <= {m_row, ma_now}; m_acc_write <= ~nwe_now;
               m_page_hit <= cas_seen; cas_seen <= 1; cas_down <= 1;
            end else if (cas_down && cas_rise) begin
               cas_down <= 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("acc_valid", bus.acc_valid, m_acc_valid);
         chk("refresh",   bus.refresh,   m_refresh);
         chk("proto_err", bus.proto_err, m_proto);
         chk("addr",      bus.addr,      m_addr);
         chk("acc_write", bus.acc_write, m_acc_write);
         if (m_acc_valid) chk("page_hit", bus.page_hit, m_page_hit);
         if (m_refresh)   chk("refresh_row", bus.refresh_row, m_refresh_row);
      end
   end

   // Event log used by the literal checks.
   logic [15:0]   acc_addr_q [$];
   logic          acc_w_q [$];
   logic          acc_ph_q [$];
   int            acc_cyc_q [$];
   logic [AW-1:0] ref_q [$];
   int            n_proto = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.acc_valid) begin
            acc_addr_q.push_back(bus.addr); acc_w_q.push_back(bus.acc_write);
            acc_ph_q.push_back(bus.page_hit); acc_cyc_q.push_back(cyc);
         end
         if (bus.refresh) ref_q.push_back(bus.refresh_row);
         if (bus.proto_err) n_proto++;
      end
   end

   task automatic wcyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_log();
      acc_addr_q.delete(); acc_w_q.delete(); acc_ph_q.delete(); acc_cyc_q.delete();
      ref_q.delete(); n_proto = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0; bus.nras = 1; bus.ncas = 1; bus.nwe = 1; bus.ma = 0;
      wcyc(3);
      rst_n = 1;
      wcyc(2);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_addr"},  bus.addr, 0);
      chk({tag, "_av"},    bus.acc_valid, 0);
      chk({tag, "_aw"},    bus.acc_write, 0);
      chk({tag, "_ph"},    bus.page_hit, 0);
      chk({tag, "_ref"},   bus.refresh, 0);
      chk({tag, "_rrow"},  bus.refresh_row, 0);
      chk({tag, "_perr"},  bus.proto_err, 0);
   endtask

   task automatic cbr_cycle();
      bus.ncas = 0; wcyc(4);
      bus.nras = 0; wcyc(4);
      bus.nras = 1; wcyc(4);
      bus.ncas = 1; wcyc(4);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      rst_n = 0; bus.nras = 1; bus.ncas = 1; bus.nwe = 1; bus.ma = 0;
      wcyc(3);
      check_outputs_zero("reset");
      rst_n = 1;
      wcyc(3);

      // Read access and latency
      clear_log();
      bus.ma = 8'h12; bus.nras = 0; wcyc(4);
      bus.ma = 8'h34; bus.nwe = 1; bus.ncas = 0; c0 = cyc; wcyc(6);
      bus.ncas = 1; bus.nras = 1; wcyc(6);
      chk("read_cnt", acc_addr_q.size(), 1);
      chk("read_addr", acc_addr_q[0], 16'h1234);
      chk("read_w", acc_w_q[0], 0);
      chk("read_ph", acc_ph_q[0], 0);
      chk("read_lat", acc_cyc_q[0] - c0, S + 1);
      chk("read_noref", ref_q.size(), 0);

      // Page mode writes
      clear_log();
      bus.ma = 8'hA5; bus.nras = 0; wcyc(4);
      for (int i = 1; i <= 3; i++) begin
         bus.ma = 8'(i); bus.nwe = 0; bus.ncas = 0; wcyc(4);
         bus.ncas = 1; wcyc(4);
      end
      bus.nras = 1; bus.nwe = 1; wcyc(6);
      chk("page_cnt", acc_addr_q.size(), 3);
      chk("page_a0", acc_addr_q[0], 16'hA501);
      chk("page_a1", acc_addr_q[1], 16'hA502);
      chk("page_a2", acc_addr_q[2], 16'hA503);
      chk("page_w", {acc_w_q[0], acc_w_q[1], acc_w_q[2]}, 3'b111);
      chk("page_ph", {acc_ph_q[0], acc_ph_q[1], acc_ph_q[2]}, 3'b011);
      chk("page_noref", ref_q.size(), 0);

      // RAS-only refresh
      clear_log();
      bus.ma = 8'h7F; bus.nras = 0; wcyc(4);
      bus.nras = 1; wcyc(6);
      chk("ror_cnt", ref_q.size(), 1);
      chk("ror_row", ref_q[0], 8'h7F);
      chk("ror_noacc", acc_addr_q.size(), 0);

      // CAS-before-RAS counter and wrap
      do_reset();
      clear_log();
      for (int i = 0; i < 257; i++) cbr_cycle();
      chk("cbr_cnt", ref_q.size(), 257);
      chk("cbr_r0", ref_q[0], 8'h00);
      chk("cbr_r1", ref_q[1], 8'h01);
      chk("cbr_r2", ref_q[2], 8'h02);
      chk("cbr_r255", ref_q[255], 8'hFF);
      chk("cbr_r256", ref_q[256], 8'h00);
      chk("cbr_noacc", acc_addr_q.size(), 0);
      chk("cbr_noerr", n_proto, 0);

      // Simultaneous strobes, then a normal write
      clear_log();
      bus.ma = 8'h99; bus.nras = 0; bus.ncas = 0; wcyc(4);
      bus.nras = 1; bus.ncas = 1; wcyc(6);
      chk("err_cnt", n_proto, 1);
      chk("err_noacc", acc_addr_q.size(), 0);
      chk("err_noref", ref_q.size(), 0);
      bus.ma = 8'h3C; bus.nras = 0; wcyc(4);
      bus.ma = 8'hC3; bus.nwe = 0; bus.ncas = 0; wcyc(5);
      bus.ncas = 1; bus.nras = 1; bus.nwe = 1; wcyc(6);
      chk("post_err_cnt", acc_addr_q.size(), 1);
      chk("post_err_addr", acc_addr_q[0], 16'h3CC3);
      chk("post_err_w", acc_w_q[0], 1);
      chk("post_err_ph", acc_ph_q[0], 0);

      // Reset while a column is held
      bus.ma = 8'h55; bus.nras = 0; wcyc(4);
      bus.ma = 8'h66; bus.ncas = 0; wcyc(6);
      chk("col_addr", bus.addr, 16'h5566);
      #3 rst_n = 0;
      #1 check_outputs_zero("midreset");
      @(negedge clk);
      bus.nras = 1; bus.ncas = 1;
      wcyc(3);
      rst_n = 1;
      clear_log();
      for (int i = 0; i < 3; i++) begin
         wcyc(4); bus.ncas = 0;
         wcyc(4); bus.ncas = 1;
      end
      wcyc(6);
      chk("rst_noacc", acc_addr_q.size(), 0);
      chk("rst_noref", ref_q.size(), 0);
      chk("rst_noerr", n_proto, 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
